// File: rtl/ifid_stall_ctrl.sv
// IF/ID pipeline register with stall hold, flush squash and a saturating stall counter.
// pc_en and bubble_ex are combinational; every other output comes straight from a register.
module ifid_stall_ctrl #(
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [15:0] NOP_INSTR    = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] instr_if,
    input  logic [15:0] pc_plus2_if,
    input  logic        valid_if,
    output logic        pc_en,
    output logic        bubble_ex,
    output logic [15:0] instr_id,
    output logic [15:0] pc_plus2_id,
    output logic        valid_id,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_SQUASH = 2'b10
    } state_t;

    // Squash edges still owed after the flush edge itself
    localparam logic [2:0] SQ_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [2:0]  r_sq_cnt;
    logic [15:0] r_instr_id;
    logic [15:0] r_pc_plus2_id;
    logic        r_valid_id;
    logic [15:0] r_stall_cnt;

    state_t      w_state_nxt;
    logic [2:0]  w_sq_cnt_nxt;
    logic [15:0] w_instr_nxt;
    logic [15:0] w_pc_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_stall_cnt_nxt;
    logic        w_pc_en;
    logic        w_bubble_ex;

    // Next-state and control decode; priority flush > squash > stall > fetch
    always_comb begin
        w_state_nxt     = r_state;
        w_sq_cnt_nxt    = r_sq_cnt;
        w_instr_nxt     = r_instr_id;
        w_pc_nxt        = r_pc_plus2_id;
        w_valid_nxt     = r_valid_id;
        w_stall_cnt_nxt = r_stall_cnt;
        w_pc_en         = 1'b1;
        w_bubble_ex     = 1'b0;
        if (rst) begin
            w_state_nxt  = ST_RUN;
            w_sq_cnt_nxt = 3'd0;
        end else if (flush) begin
            w_instr_nxt = NOP_INSTR;
            w_valid_nxt = 1'b0;
            w_bubble_ex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_state_nxt  = ST_SQUASH;
                w_sq_cnt_nxt = SQ_RELOAD;
            end else begin
                w_state_nxt  = ST_RUN;
                w_sq_cnt_nxt = 3'd0;
            end
        end else begin
            case (r_state)
                ST_SQUASH: begin
                    w_instr_nxt = NOP_INSTR;
                    w_valid_nxt = 1'b0;
                    if (r_sq_cnt <= 3'd1) begin
                        w_state_nxt  = ST_RUN;
                        w_sq_cnt_nxt = 3'd0;
                    end else begin
                        w_state_nxt  = ST_SQUASH;
                        w_sq_cnt_nxt = r_sq_cnt - 3'd1;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (stall) begin
                        w_pc_en     = 1'b0;
                        w_bubble_ex = 1'b1;
                        w_state_nxt = ST_HOLD;
                        if (r_stall_cnt == 16'hFFFF) begin
                            w_stall_cnt_nxt = r_stall_cnt;
                        end else begin
                            w_stall_cnt_nxt = r_stall_cnt + 16'd1;
                        end
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_pc_nxt    = pc_plus2_if;
                        w_valid_nxt = valid_if;
                        if (valid_if) begin
                            w_instr_nxt = instr_if;
                        end else begin
                            w_instr_nxt = NOP_INSTR;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_sq_cnt_nxt = 3'd0;
                    w_instr_nxt  = NOP_INSTR;
                    w_valid_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Pipeline register, state and counters with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_sq_cnt      <= 3'd0;
            r_instr_id    <= NOP_INSTR;
            r_pc_plus2_id <= 16'h0000;
            r_valid_id    <= 1'b0;
            r_stall_cnt   <= 16'h0000;
        end else begin
            r_state       <= w_state_nxt;
            r_sq_cnt      <= w_sq_cnt_nxt;
            r_instr_id    <= w_instr_nxt;
            r_pc_plus2_id <= w_pc_nxt;
            r_valid_id    <= w_valid_nxt;
            r_stall_cnt   <= w_stall_cnt_nxt;
        end
    end

    assign pc_en       = w_pc_en;
    assign bubble_ex   = w_bubble_ex;
    assign instr_id    = r_instr_id;
    assign pc_plus2_id = r_pc_plus2_id;
    assign valid_id    = r_valid_id;
    assign state       = r_state;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// Bench for ifid_stall_ctrl: two instances (FLUSH_CYCLES=2 and 1) against a cycle-level
// reference model, plus a directed vector table, counter saturation and random traffic.
module tb_ifid_stall_ctrl;

    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, valid_if;
    logic [15:0] instr_if, pc_plus2_if;

    logic [1:0]        o_pe, o_bub, o_valid;
    logic [1:0][15:0]  o_instr, o_pc, o_cnt;
    logic [1:0][1:0]   o_st;

    ifid_stall_ctrl #(.FLUSH_CYCLES(2), .NOP_INSTR(16'h0800)) u_dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .instr_if(instr_if), .pc_plus2_if(pc_plus2_if), .valid_if(valid_if),
        .pc_en(o_pe[0]), .bubble_ex(o_bub[0]), .instr_id(o_instr[0]),
        .pc_plus2_id(o_pc[0]), .valid_id(o_valid[0]), .state(o_st[0]), .stall_cnt(o_cnt[0])
    );

    ifid_stall_ctrl #(.FLUSH_CYCLES(1), .NOP_INSTR(16'h0800)) u_dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .instr_if(instr_if), .pc_plus2_if(pc_plus2_if), .valid_if(valid_if),
        .pc_en(o_pe[1]), .bubble_ex(o_bub[1]), .instr_id(o_instr[1]),
        .pc_plus2_id(o_pc[1]), .valid_id(o_valid[1]), .state(o_st[1]), .stall_cnt(o_cnt[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: squash edges left, hold flag, IF/ID contents, stall count
    int          fc[2] = '{2, 1};
    int          m_left[2];
    bit          m_hold[2];
    bit          m_pck[2];
    logic [15:0] m_instr[2];
    logic [15:0] m_pc[2];
    logic        m_valid[2];
    int          m_cnt[2];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic v,
                        input logic [15:0] ins, input logic [15:0] pc,
                        output logic pe_s, output logic bub_s);
        logic e_pe, e_bub;
        string tag;
        rst = r; stall = s; flush = f; valid_if = v; instr_if = ins; pc_plus2_if = pc;
        #2;
        pe_s  = o_pe[0];
        bub_s = o_bub[0];
        for (int k = 0; k < 2; k++) begin
            tag = (k == 0) ? "fc2" : "fc1";
            if (r)                 begin e_pe = 1'b1; e_bub = 1'b0; end
            else if (f)            begin e_pe = 1'b1; e_bub = 1'b1; end
            else if (m_left[k] > 0) begin e_pe = 1'b1; e_bub = 1'b0; end
            else if (s)            begin e_pe = 1'b0; e_bub = 1'b1; end
            else                   begin e_pe = 1'b1; e_bub = 1'b0; end
            chk({tag, " pc_en"}, 16'(o_pe[k]), 16'(e_pe));
            chk({tag, " bubble_ex"}, 16'(o_bub[k]), 16'(e_bub));
            if (r) begin
                m_instr[k] = NOP; m_valid[k] = 1'b0; m_pc[k] = 16'h0000; m_pck[k] = 1'b1;
                m_hold[k] = 1'b0; m_left[k] = 0; m_cnt[k] = 0;
            end else if (f) begin
                m_instr[k] = NOP; m_valid[k] = 1'b0; m_pck[k] = 1'b0;
                m_hold[k] = 1'b0; m_left[k] = fc[k] - 1;
            end else if (m_left[k] > 0) begin
                m_instr[k] = NOP; m_valid[k] = 1'b0; m_pck[k] = 1'b0;
                m_hold[k] = 1'b0; m_left[k] = m_left[k] - 1;
            end else if (s) begin
                m_hold[k] = 1'b1;
                if (m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
            end else begin
                m_hold[k] = 1'b0; m_valid[k] = v; m_instr[k] = v ? ins : NOP;
                m_pc[k] = pc; m_pck[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            tag = (k == 0) ? "fc2" : "fc1";
            chk({tag, " instr_id"}, o_instr[k], m_instr[k]);
            chk({tag, " valid_id"}, 16'(o_valid[k]), 16'(m_valid[k]));
            chk({tag, " state"}, 16'(o_st[k]),
                (m_left[k] > 0) ? 16'd2 : (m_hold[k] ? 16'd1 : 16'd0));
            chk({tag, " stall_cnt"}, o_cnt[k], 16'(m_cnt[k]));
            if (m_pck[k]) chk({tag, " pc_plus2_id"}, o_pc[k], m_pc[k]);
        end
    endtask

    typedef struct {
        logic        r, s, f, v;
        logic [15:0] ins, pc;
        logic        e_pe, e_bub;
        logic [15:0] e_instr;
        logic        e_valid;
        logic [1:0]  e_st;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic pe_s, bub_s;
        logic r, s, f, v;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_hold[k] = 1'b0; m_pck[k] = 1'b0;
            m_instr[k] = NOP; m_pc[k] = 16'h0000; m_valid[k] = 1'b0; m_cnt[k] = 0;
        end
        //            r     s     f     v     ins       pc        pe    bub   instr     vld   st     cnt
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC123, 16'h0002, 1'b1, 1'b0, 16'hC123, 1'b1, 2'b00, 16'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hC456, 16'h0004, 1'b0, 1'b1, 16'hC123, 1'b1, 2'b01, 16'd1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hC456, 16'h0004, 1'b0, 1'b1, 16'hC123, 1'b1, 2'b01, 16'd2};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC456, 16'h0004, 1'b1, 1'b0, 16'hC456, 1'b1, 2'b00, 16'd2};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hC789, 16'h0006, 1'b1, 1'b1, 16'h0800, 1'b0, 2'b10, 16'd2};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC789, 16'h0040, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd2};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC789, 16'h0040, 1'b1, 1'b0, 16'hC789, 1'b1, 2'b00, 16'd2};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'hC78A, 16'h0042, 1'b1, 1'b1, 16'h0800, 1'b0, 2'b10, 16'd2};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hC78B, 16'h0044, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hC999, 16'h0080, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd2};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hCAAA, 16'h0082, 1'b0, 1'b1, 16'h0800, 1'b0, 2'b01, 16'd3};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hCAAA, 16'h0082, 1'b1, 1'b0, 16'h0800, 1'b0, 2'b00, 16'd0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC111, 16'h0010, 1'b1, 1'b0, 16'hC111, 1'b1, 2'b00, 16'd0};

        rst = 1'b1; stall = 1'b0; flush = 1'b0; valid_if = 1'b0;
        instr_if = 16'h0000; pc_plus2_if = 16'h0000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].ins, tbl[i].pc, pe_s, bub_s);
            chk($sformatf("vec%0d pc_en", i), 16'(pe_s), 16'(tbl[i].e_pe));
            chk($sformatf("vec%0d bubble_ex", i), 16'(bub_s), 16'(tbl[i].e_bub));
            chk($sformatf("vec%0d instr_id", i), o_instr[0], tbl[i].e_instr);
            chk($sformatf("vec%0d valid_id", i), 16'(o_valid[0]), 16'(tbl[i].e_valid));
            chk($sformatf("vec%0d state", i), 16'(o_st[0]), 16'(tbl[i].e_st));
            chk($sformatf("vec%0d stall_cnt", i), o_cnt[0], tbl[i].e_cnt);
        end

        // Saturation: long stall run, then reset while holding
        for (int i = 0; i < 65540; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 16'hC222, 16'h0012, pe_s, bub_s);
        end
        chk("sat stall_cnt a", o_cnt[0], 16'hFFFF);
        chk("sat stall_cnt b", o_cnt[1], 16'hFFFF);
        chk("sat instr held", o_instr[0], 16'hC111);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hC222, 16'h0012, pe_s, bub_s);
        chk("sat stays", o_cnt[0], 16'hFFFF);
        chk("sat state hold", 16'(o_st[0]), 16'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'hC222, 16'h0012, pe_s, bub_s);
        chk("rst-in-hold pc_en", 16'(pe_s), 16'd1);
        chk("rst-in-hold stall_cnt", o_cnt[0], 16'h0000);
        chk("rst-in-hold state", 16'(o_st[0]), 16'd0);
        chk("rst-in-hold instr", o_instr[0], 16'h0800);

        // Reset in the middle of a squash
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hC333, 16'h0020, pe_s, bub_s);
        chk("pre-rst squash state", 16'(o_st[0]), 16'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'hC333, 16'h0020, pe_s, bub_s);
        chk("rst-in-squash state", 16'(o_st[0]), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'hC444, 16'h0022, pe_s, bub_s);
        chk("post-rst fetch", o_instr[0], 16'hC444);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) < 2);
            f = ($urandom_range(0, 99) < 12);
            s = ($urandom_range(0, 99) < 35);
            v = ($urandom_range(0, 99) < 80);
            step(r, s, f, v, 16'($urandom), 16'($urandom), pe_s, bub_s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifid_stall_ctrl.md
# ifid_stall_ctrl

IF/ID pipeline register and stall/flush response unit. Consumes the STALL signal from the hazard detector and the branch-resolution flush from EX. It holds or advances the PC and the IF/ID latch, injects NOP bubbles into ID/EX, and squashes wrong-path fetches. It sits between the fetch stage and the decode stage and counts stall cycles for performance monitoring.

## Interface
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is loaded with NOP per flush; legal range 1..4
- NOP_INSTR, 16'h0800, instruction word loaded into IF/ID when squashing or when no valid fetch exists
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard detected on the instruction currently in ID
- flush  in  1  taken branch/jump resolved in EX; wrong-path instructions must be discarded
- instr_if  in  16  fetched instruction
- pc_plus2_if  in  16  PC+2 of fetched instruction
- valid_if  in  1  fetch result valid this cycle
- pc_en  out  1  PC register write enable (combinational)
- bubble_ex  out  1  force ID/EX control bits to zero this cycle (combinational)
- instr_id  out  16  IF/ID instruction (registered)
- pc_plus2_id  out  16  IF/ID PC+2 (registered)
- valid_id  out  1  IF/ID holds a real instruction (registered)
- state  out  2  00 RUN, 01 HOLD, 10 SQUASH (registered)
- stall_cnt  out  16  saturating count of stalled cycles (registered)

## Operation
- Priority per cycle: rst > flush > SQUASH state > stall > valid_if.
- rst: instr_id=NOP_INSTR, pc_plus2_id=0, valid_id=0, state=RUN, squash counter=0, stall_cnt=0.
- flush=1, any state: IF/ID loads NOP_INSTR, valid_id=0, pc_en=1, bubble_ex=1, stall ignored, stall_cnt unchanged.
  - If FLUSH_CYCLES>1: state→SQUASH, squash counter=FLUSH_CYCLES-1. Otherwise state→RUN.
- SQUASH with no flush: IF/ID loads NOP_INSTR, valid_id=0, pc_en=1, bubble_ex=0. stall and valid_if are ignored.
  - Counter decrements; when it reaches 1→0, state→RUN next cycle.
  - A flush during SQUASH reloads the counter.
- RUN/HOLD, stall=1, no flush: IF/ID holds all fields, pc_en=0, bubble_ex=1, state→HOLD, stall_cnt+=1, saturating at 16'hFFFF.
- RUN/HOLD, stall=0, no flush: state→RUN, pc_en=1, bubble_ex=0.
  - valid_if=1: IF/ID loads instr_if, pc_plus2_if, and valid_id=1.
  - valid_if=0: IF/ID loads NOP_INSTR, pc_plus2_if, and valid_id=0.
- stall_cnt never wraps; it clears only on rst.

## Timing
- pc_en and bubble_ex are purely combinational from stall, flush, and state, with zero latency. They are valid in the same cycle the hazard detector asserts stall.
- IF/ID fields and state update one cycle after the inputs are sampled.
- A stall asserted for N consecutive cycles holds IF/ID for exactly N edges. The instruction advances on the first edge with stall=0.
- Flush latency: wrong-path instructions are removed starting at the flush edge. The first correct-path fetch is latched FLUSH_CYCLES edges after the flush edge.
- Simultaneous stall and flush: flush wins. The stalled ID instruction is on the wrong path and is discarded, and stall_cnt does not increment.
- rst asserted mid-HOLD or mid-SQUASH: all registers return to reset values on that edge, and pc_en=1, bubble_ex=0 during rst.

## Test plan
- Reset then straight-line fetch: rst for 2 cycles; instr_if 16'hC123/16'hC456 with valid_if=1 → instr_id follows one cycle later, valid_id=1, pc_en=1, state=00.
- Single stall: stall=1 for 2 cycles while instr_id=16'hC123 → pc_en=0 and bubble_ex=1 for both cycles; instr_id held; state=01; stall_cnt=2; advances to next instruction on 3rd edge.
- Flush with FLUSH_CYCLES=2: flush=1 one cycle → instr_id=16'h0800, valid_id=0 for 2 edges, state 10 then 00; third edge latches instr_if.
- Stall and flush together: stall=1, flush=1 → pc_en=1, bubble_ex=1, instr_id=16'h0800, stall_cnt unchanged.
- Fetch not ready: valid_if=0, stall=0 → instr_id=16'h0800, valid_id=0, pc_en=1.
- Saturation and reset: preload via 65540 stall cycles → stall_cnt=16'hFFFF and stays there; rst during HOLD → stall_cnt=0, state=00, instr_id=16'h0800 on that edge.
